tt_sweep_checker: RTL

Parametrised, synthesizable exhaustive truth-table checker for N-input single-output combinational blocks. It drives every input combination onto the DUT and waits a programmable settle time. It then samples the DUT output, compares it against an expected truth table and reports the mismatch count, the first failing vector and pass/fail. It is the in-fabric successor to the team's hand-written 3-input stimulus benches, generalised in input width, settle time and sweep order.

---
 rtl/tt_sweep_if.sv | 25 ++
 rtl/tt_sweep_checker.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tt_sweep_if.sv
// Handshake/result bundle between the exhaustive truth-table checker and its user.
// master = checker side, slave = stimulus/DUT side.
interface tt_sweep_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    modport master (
        input  start, dut_y,
        output dut_in, busy, done, pass, err_cnt, first_err_vec, first_err_valid
    );

    modport slave (
        output start, dut_y,
        input  dut_in, busy, done, pass, err_cnt, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker: sweeps all 2**N_IN input vectors, settles, samples, compares.
// Define GRAY_SWEEP_EN to sweep in Gray-code order instead of binary order.
module tt_sweep_checker #(
    parameter int                    N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]  EXP_TT = 8'b1110_1000,
    parameter int                    SETTLE = 2
) (
    input  logic      clk,
    input  logic      rst,
    tt_sweep_if.master bus
);
    localparam int              SW       = $clog2(SETTLE + 1);
    localparam int              CW       = N_IN + 1;
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t          state_r, state_nx;
    logic [N_IN-1:0] idx_r, idx_nx;
    logic [SW-1:0]   settle_r, settle_nx;
    logic [N_IN-1:0] dut_in_r, dut_in_nx;
    logic [CW-1:0]   err_r, err_nx;
    logic [N_IN-1:0] fev_r, fev_nx;
    logic            fevv_r, fevv_nx;
    logic            busy_r, busy_nx;
    logic            done_r, done_nx;
    logic            pass_r, pass_nx;
    logic            mismatch;

    function automatic logic [N_IN-1:0] vec(input logic [N_IN-1:0] i);
`ifdef GRAY_SWEEP_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Expected bit follows the vector actually on the pins, which differs from idx in Gray order.
    assign mismatch = (bus.dut_y != EXP_TT[dut_in_r]);

    always_comb begin
        state_nx  = state_r;
        idx_nx    = idx_r;
        settle_nx = settle_r;
        dut_in_nx = dut_in_r;
        err_nx    = err_r;
        fev_nx    = fev_r;
        fevv_nx   = fevv_r;
        busy_nx   = busy_r;
        done_nx   = done_r;
        pass_nx   = pass_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx  = DRIVE;
                    busy_nx   = 1'b1;
                    idx_nx    = '0;
                    dut_in_nx = vec('0);
                    settle_nx = '0;
                    err_nx    = '0;
                    fev_nx    = '0;
                    fevv_nx   = 1'b0;
                    done_nx   = 1'b0;
                    pass_nx   = 1'b0;
                end
            end
            DRIVE: begin
                settle_nx = settle_r + SW'(1);
                if (settle_r == SW'(SETTLE - 1)) state_nx = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_nx = err_r + CW'(1);
                    if (!fevv_r) begin
                        fev_nx  = dut_in_r;
                        fevv_nx = 1'b1;
                    end
                end
                if (idx_r == IDX_LAST) begin
                    state_nx = DONE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = (err_nx == '0);
                end else begin
                    state_nx  = DRIVE;
                    idx_nx    = idx_r + N_IN'(1);
                    dut_in_nx = vec(idx_r + N_IN'(1));
                    settle_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            settle_r <= '0;
            dut_in_r <= '0;
            err_r    <= '0;
            fev_r    <= '0;
            fevv_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            idx_r    <= idx_nx;
            settle_r <= settle_nx;
            dut_in_r <= dut_in_nx;
            err_r    <= err_nx;
            fev_r    <= fev_nx;
            fevv_r   <= fevv_nx;
            busy_r   <= busy_nx;
            done_r   <= done_nx;
            pass_r   <= pass_nx;
        end
    end

    assign bus.dut_in          = dut_in_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.pass            = pass_r;
    assign bus.err_cnt         = err_r;
    assign bus.first_err_vec   = fev_r;
    assign bus.first_err_valid = fevv_r;
endmodule
